// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings for the alu_pipe datapath and its pipeline wrapper.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        FuncAdd   = 3'b000,
        FuncAdc   = 3'b001,
        FuncSub   = 3'b010,
        FuncSbc   = 3'b011,
        FuncAnd   = 3'b100,
        FuncOr    = 3'b101,
        FuncXor   = 3'b110,
        FuncPassB = 3'b111
    } func_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operands, opcode and selected carry in -> result, carry, overflow.
// Overflow output exists only when ALU_PIPE_OVF_EN is defined.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  func_e            func_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] res_o,
`ifdef ALU_PIPE_OVF_EN
    output logic             ovf_o,
`endif
    output logic             carry_o
);

    logic             sub_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;

    // SUB/SBC reuse the adder with the inverted B operand; carry 1 means no borrow.
    assign sub_op = (func_i == FuncSub) || (func_i == FuncSbc);
    assign b_op   = sub_op ? ~b_i : b_i;
    assign sum    = {1'b0, a_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_i};

    always_comb begin
        res_o   = '0;
        carry_o = 1'b0;
        unique case (func_i)
            FuncAdd, FuncAdc, FuncSub, FuncSbc: begin
                res_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            FuncAnd:   res_o = a_i & b_i;
            FuncOr:    res_o = a_i | b_i;
            FuncXor:   res_o = a_i ^ b_i;
            FuncPassB: res_o = b_i;
            default:   res_o = '0;
        endcase
    end

`ifdef ALU_PIPE_OVF_EN
    // Signed overflow: both adder inputs share a sign that the sum does not.
    assign ovf_o = !func_i[2] && (a_i[WIDTH-1] == b_op[WIDTH-1])
                   && (sum[WIDTH-1] != a_i[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU pipeline: valid/ready handshake, registered result and flags, carry flag C.
// Optional overflow flag output is enabled by defining ALU_PIPE_OVF_EN.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
    input  logic [2:0]       func,
    input  logic             flags_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
`ifdef ALU_PIPE_OVF_EN
    output logic             overflow,
`endif
    output logic             negative
);

    func_e            op;
    logic             accept;
    logic             arith;
    logic             cin_sel;
    logic [WIDTH-1:0] core_res;
    logic             core_carry;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             zero_d, zero_q;
    logic             neg_d, neg_q;
    logic             c_d, c_q;

    assign op       = func_e'(func);
    assign arith    = !func[2];
    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // A coincident flags_clr makes chained ops see C=0.
    always_comb begin
        cin_sel = 1'b0;
        case (op)
            FuncAdd:          cin_sel = carry_in;
            FuncAdc, FuncSbc: cin_sel = flags_clr ? 1'b0 : c_q;
            FuncSub:          cin_sel = 1'b1;
            default:          cin_sel = 1'b0;
        endcase
    end

`ifdef ALU_PIPE_OVF_EN
    logic core_ovf;
    logic ovf_d, ovf_q;
`endif

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .a_i     (input_a),
        .b_i     (input_b),
        .func_i  (op),
        .cin_i   (cin_sel),
        .res_o   (core_res),
`ifdef ALU_PIPE_OVF_EN
        .ovf_o   (core_ovf),
`endif
        .carry_o (core_carry)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        c_d         = c_q;
`ifdef ALU_PIPE_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = core_res;
            carry_d     = core_carry;
            zero_d      = (core_res == '0);
            neg_d       = core_res[WIDTH-1];
`ifdef ALU_PIPE_OVF_EN
            ovf_d       = core_ovf;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && arith) begin
            c_d = core_carry;
        end else if (flags_clr) begin
            c_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            c_q         <= c_d;
        end
    end

`ifdef ALU_PIPE_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8); overflow checks under ALU_PIPE_OVF_EN.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] input_a;
    logic [7:0] input_b;
    logic       carry_in;
    logic [2:0] func;
    logic       flags_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       negative;
`ifdef ALU_PIPE_OVF_EN
    logic       overflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_a   (input_a),
        .input_b   (input_b),
        .carry_in  (carry_in),
        .func      (func),
        .flags_clr (flags_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
`ifdef ALU_PIPE_OVF_EN
        .overflow  (overflow),
`endif
        .negative  (negative)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic c,
                             input logic z, input logic n);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".res"}, result, res);
        check({tag, ".carry"}, carry_out, c);
        check({tag, ".zero"}, zero, z);
        check({tag, ".neg"}, negative, n);
    endtask

    // Offer one op for a single cycle with out_ready high; returns #1 after the accepting edge.
    task automatic do_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic clr);
        @(negedge clk);
        in_valid  = 1'b1;
        func      = f;
        input_a   = a;
        input_b   = b;
        carry_in  = cin;
        flags_clr = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flags_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        input_a   = '0;
        input_b   = '0;
        carry_in  = 1'b0;
        func      = 3'b000;
        flags_clr = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", out_valid, 1'b0);
        check("rst.res", result, 8'h00);
        check("rst.flags", {carry_out, zero, negative}, 3'b000);
        check("rst.in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle.in_ready", in_ready, 1'b1);

        // Carry chain
        do_op(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
        check_out("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef ALU_PIPE_OVF_EN
        check("add_ff_01.ovf", overflow, 1'b0);
`endif
        do_op(3'b001, 8'h00, 8'h00, 1'b0, 1'b0);
        check_out("adc_chain", 8'h01, 1'b0, 1'b0, 1'b0);

        do_op(3'b010, 8'h05, 8'h07, 1'b0, 1'b0);
        check_out("sub_5_7", 8'hFE, 1'b0, 1'b0, 1'b1);
        do_op(3'b000, 8'h12, 8'h34, 1'b1, 1'b0);
        check_out("add_cin", 8'h47, 1'b0, 1'b0, 1'b0);

        // Logical ops, C must survive them
        do_op(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(3'b100, 8'hF0, 8'h3C, 1'b0, 1'b0);
        check_out("and", 8'h30, 1'b0, 1'b0, 1'b0);
        do_op(3'b101, 8'hF0, 8'h0F, 1'b0, 1'b0);
        check_out("or", 8'hFF, 1'b0, 1'b0, 1'b1);
        do_op(3'b110, 8'hAA, 8'hFF, 1'b0, 1'b0);
        check_out("xor", 8'h55, 1'b0, 1'b0, 1'b0);
        do_op(3'b111, 8'h11, 8'h80, 1'b0, 1'b0);
        check_out("passb", 8'h80, 1'b0, 1'b0, 1'b1);
        do_op(3'b001, 8'h00, 8'h00, 1'b0, 1'b0);
        check_out("adc_after_logic", 8'h01, 1'b0, 1'b0, 1'b0);

        // C=0 now: SBC 5-3 without borrow-in gives 5+FC+0
        do_op(3'b011, 8'h05, 8'h03, 1'b0, 1'b0);
        check_out("sbc_c0", 8'h01, 1'b1, 1'b0, 1'b0);
        do_op(3'b011, 8'h05, 8'h03, 1'b0, 1'b0);
        check_out("sbc_c1", 8'h02, 1'b1, 1'b0, 1'b0);

`ifdef ALU_PIPE_OVF_EN
        do_op(3'b010, 8'h80, 8'h01, 1'b0, 1'b0);
        check_out("sub_80_01", 8'h7F, 1'b1, 1'b0, 1'b0);
        check("sub_80_01.ovf", overflow, 1'b1);
        do_op(3'b110, 8'h80, 8'h01, 1'b0, 1'b0);
        check("xor.ovf", overflow, 1'b0);
`endif

        // flags_clr coinciding with ADC
        do_op(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(3'b001, 8'h10, 8'h00, 1'b0, 1'b1);
        check_out("adc_clr", 8'h10, 1'b0, 1'b0, 1'b0);
        do_op(3'b001, 8'h00, 8'h00, 1'b0, 1'b0);
        check_out("adc_after_clr", 8'h00, 1'b0, 1'b1, 1'b0);

        // Standalone flags_clr with no op
        do_op(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        do_op(3'b001, 8'h00, 8'h00, 1'b0, 1'b0);
        check_out("adc_after_idle_clr", 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure
        do_op(3'b000, 8'h03, 8'h04, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        func      = 3'b000;
        input_a   = 8'h01;
        input_b   = 8'h01;
        carry_in  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp.in_ready", in_ready, 1'b0);
            check("bp.valid", out_valid, 1'b1);
            check("bp.res", result, 8'h07);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("bp.next", 8'h02, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("drain.valid", out_valid, 1'b0);

        // Reset with pending output and C=1
        do_op(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
        check("pre_rst.valid", out_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst2.valid", out_valid, 1'b0);
        check("rst2.res", result, 8'h00);
        check("rst2.flags", {carry_out, zero, negative}, 3'b000);
`ifdef ALU_PIPE_OVF_EN
        check("rst2.ovf", overflow, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b001, 8'h00, 8'h00, 1'b0, 1'b0);
        check_out("adc_after_rst", 8'h00, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
